// File: rtl/apb_slave_regfile.sv
// APB3 completer fronting a DEPTH x 32-bit register file, with configurable wait states and PSLVERR on bad addresses.
// Latency: one setup cycle plus WAIT_CYCLES+1 access cycles; pready is decoded from registered state only.
// Backpressure: the completer holds pready low for the wait states; a master that leaves the access early sets proto_err.
module apb_slave_regfile #(
    parameter int DEPTH       = 16,
    parameter int ADDR_WIDTH  = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  pclk,
    input  logic                  prst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  pwrite,
    input  logic [31:0]           pwdata,
    output logic                  pready,
    output logic [31:0]           prdata,
    output logic                  pslverr,
    output logic                  proto_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(DEPTH * 4);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic [IDX_W-1:0] lat_idx;
    logic             lat_write;
    logic             lat_err;
    logic [31:0]      lat_wdata;
    logic [31:0]      regs [DEPTH];

    logic             setup_err;
    logic [IDX_W-1:0] setup_idx;

    always_comb begin
        setup_idx = paddr[IDX_W+1:2];
        setup_err = (paddr[1:0] != 2'b00) || ({1'b0, paddr} >= ADDR_LIMIT);
    end

    assign pready  = (state == ACCESS) && (cnt == 4'd0);
    assign pslverr = pready && lat_err;

    always_ff @(posedge pclk) begin
        if (prst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_idx   <= '0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            lat_wdata <= 32'd0;
            prdata    <= 32'd0;
            proto_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= 32'd0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (psel && !penable) begin
                        lat_idx   <= setup_idx;
                        lat_write <= pwrite;
                        lat_err   <= setup_err;
                        lat_wdata <= pwdata;
                        cnt       <= 4'(WAIT_CYCLES);
                        // Read data is fetched at setup so the access phase only has to count waits.
                        prdata    <= (!pwrite && !setup_err) ? regs[setup_idx] : 32'd0;
                        state     <= ACCESS;
                    end else if (psel && penable) begin
                        proto_err <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (psel && penable) begin
                        if (cnt != 4'd0) begin
                            cnt <= cnt - 4'd1;
                        end else begin
                            if (lat_write && !lat_err) begin
                                regs[lat_idx] <= lat_wdata;
                            end
                            state <= IDLE;
                        end
                    end else begin
                        // Master left the access phase early: drop the transfer without writing.
                        proto_err <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench: three completers (0, 2 and 3 wait states) share one APB bus, each selected by its own psel.
module tb_apb_slave_regfile;

    logic        pclk = 1'b0;
    logic        prst;
    logic [2:0]  psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [2:0]  pready;
    logic [2:0]  pslverr;
    logic [2:0]  proto_err;
    logic [31:0] prdata [3];

    int n_vec = 0;
    int n_bad = 0;
    int waits [3] = '{0, 2, 3};

    always #5 pclk = ~pclk;

    apb_slave_regfile #(.DEPTH(16), .ADDR_WIDTH(32), .WAIT_CYCLES(0)) u_w0 (
        .pclk(pclk), .prst(prst), .psel(psel[0]), .penable(penable), .paddr(paddr),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready[0]), .prdata(prdata[0]),
        .pslverr(pslverr[0]), .proto_err(proto_err[0]));

    apb_slave_regfile #(.DEPTH(16), .ADDR_WIDTH(32), .WAIT_CYCLES(2)) u_w2 (
        .pclk(pclk), .prst(prst), .psel(psel[1]), .penable(penable), .paddr(paddr),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready[1]), .prdata(prdata[1]),
        .pslverr(pslverr[1]), .proto_err(proto_err[1]));

    apb_slave_regfile #(.DEPTH(16), .ADDR_WIDTH(32), .WAIT_CYCLES(3)) u_w3 (
        .pclk(pclk), .prst(prst), .psel(psel[2]), .penable(penable), .paddr(paddr),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready[2]), .prdata(prdata[2]),
        .pslverr(pslverr[2]), .proto_err(proto_err[2]));

    typedef struct {
        int          dut;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Full transfer starting right after an edge; returns the number of edges consumed.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int edges);
        psel    = 3'b000;
        psel[d] = 1'b1;
        penable = 1'b0;
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wdata;
        tick();
        penable = 1'b1;
        paddr   = 32'hFFFF_FFF3;
        pwdata  = 32'h0BAD_0BAD;
        edges   = 1;
        while (!pready[d] && edges < 40) begin
            tick();
            edges++;
        end
        rdata = prdata[d];
        err   = pslverr[d];
        tick();
        edges++;
        psel    = 3'b000;
        penable = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          ed;

        prst = 1'b1; psel = 3'b000; penable = 1'b0; paddr = '0; pwrite = 1'b0; pwdata = '0;
        tick();
        tick();
        prst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_pready%0d", d), 32'(pready[d]), 32'd0);
            chk($sformatf("reset_pslverr%0d", d), 32'(pslverr[d]), 32'd0);
            chk($sformatf("reset_prdata%0d", d), prdata[d], 32'd0);
            chk($sformatf("reset_proto%0d", d), 32'(proto_err[d]), 32'd0);
        end

        tbl[0]  = '{0, 1'b1, 32'h08, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{0, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{2, 1'b0, 32'h04, 32'h0,        32'h0,        1'b0};
        tbl[3]  = '{2, 1'b1, 32'h04, 32'h12345678, 32'h0,        1'b0};
        tbl[4]  = '{2, 1'b0, 32'h04, 32'h0,        32'h12345678, 1'b0};
        tbl[5]  = '{1, 1'b1, 32'h40, 32'hA5A5A5A5, 32'h0,        1'b1};
        tbl[6]  = '{1, 1'b0, 32'h06, 32'h0,        32'h0,        1'b1};
        tbl[7]  = '{0, 1'b1, 32'h00, 32'h1,        32'h0,        1'b0};
        tbl[8]  = '{0, 1'b1, 32'h04, 32'h2,        32'h0,        1'b0};
        tbl[9]  = '{0, 1'b1, 32'h3C, 32'h3,        32'h0,        1'b0};
        tbl[10] = '{0, 1'b0, 32'h00, 32'h0,        32'h1,        1'b0};
        tbl[11] = '{0, 1'b0, 32'h04, 32'h0,        32'h2,        1'b0};
        tbl[12] = '{0, 1'b0, 32'h3C, 32'h0,        32'h3,        1'b0};

        for (int i = 0; i < 13; i++) begin
            xfer(tbl[i].dut, tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd, er, ed);
            chk($sformatf("vec%0d_prdata", i), rd, tbl[i].exp_rdata);
            chk($sformatf("vec%0d_pslverr", i), 32'(er), 32'(tbl[i].exp_err));
            chk($sformatf("vec%0d_cycles", i), 32'(ed), 32'(waits[tbl[i].dut] + 2));
        end

        // Read data must persist through idle cycles.
        tick(); tick(); tick();
        chk("prdata_hold", prdata[0], 32'h3);

        // Errored accesses must leave the 2-wait register file untouched.
        for (int r = 0; r < 16; r++) begin
            xfer(1, 1'b0, 32'(r * 4), 32'h0, rd, er, ed);
            chk($sformatf("clean_reg%0d", r), rd, 32'h0);
        end
        chk("err_no_proto", 32'(proto_err[1]), 32'd0);

        // Abandon a 2-wait write by dropping psel mid-access.
        psel = 3'b010; penable = 1'b0; paddr = 32'h0C; pwrite = 1'b1; pwdata = 32'hFF;
        tick();
        penable = 1'b1;
        tick();
        chk("abort_wait_pready", 32'(pready[1]), 32'd0);
        psel = 3'b000; penable = 1'b0;
        tick();
        chk("abort_proto", 32'(proto_err[1]), 32'd1);
        chk("abort_pready", 32'(pready[1]), 32'd0);
        xfer(1, 1'b0, 32'h0C, 32'h0, rd, er, ed);
        chk("abort_no_write", rd, 32'h0);
        chk("abort_next_cycles", 32'(ed), 32'd4);
        chk("abort_next_err", 32'(er), 32'd0);

        // Access phase without a setup phase.
        psel = 3'b001; penable = 1'b1; paddr = 32'h0; pwrite = 1'b0;
        tick();
        psel = 3'b000; penable = 1'b0;
        chk("nosetup_proto", 32'(proto_err[0]), 32'd1);
        chk("nosetup_pready", 32'(pready[0]), 32'd0);
        xfer(0, 1'b0, 32'h04, 32'h0, rd, er, ed);
        chk("nosetup_next", rd, 32'h2);

        // Reset in the middle of a 3-wait write.
        psel = 3'b100; penable = 1'b0; paddr = 32'h10; pwrite = 1'b1; pwdata = 32'hCAFEF00D;
        tick();
        penable = 1'b1;
        tick();
        prst = 1'b1;
        tick();
        prst = 1'b0; psel = 3'b000; penable = 1'b0;
        chk("rst_pready", 32'(pready[2]), 32'd0);
        chk("rst_pslverr", 32'(pslverr[2]), 32'd0);
        chk("rst_prdata", prdata[2], 32'd0);
        chk("rst_proto", 32'(proto_err[2]), 32'd0);
        chk("rst_proto_w2", 32'(proto_err[1]), 32'd0);
        tick();
        xfer(2, 1'b0, 32'h10, 32'h0, rd, er, ed);
        chk("rst_no_write", rd, 32'h0);
        xfer(2, 1'b0, 32'h04, 32'h0, rd, er, ed);
        chk("rst_cleared", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB3 completer (slave) that terminates transfers from the team's APB master on the peripheral side.
- Contains a DEPTH x 32-bit register file.
- Inserts a parameterised number of wait states and flags out-of-range or misaligned accesses with PSLVERR.
- Detects master protocol violations and records them in a sticky status flag.

Parameters:
- DEPTH, 16: number of 32-bit registers; legal byte addresses are 0 .. DEPTH*4-4.
- ADDR_WIDTH, 32: width of paddr.
- WAIT_CYCLES, 0: wait states inserted before pready asserts, range 0..15.

Ports:
- pclk  in  1  APB clock; all logic on its rising edge
- prst  in  1  synchronous, active-high reset
- psel  in  1  select from master
- penable  in  1  enable (access phase) from master
- paddr  in  ADDR_WIDTH  byte address
- pwrite  in  1  1 = write, 0 = read
- pwdata  in  32  write data
- pready  out  1  transfer completion
- prdata  out  32  read data, valid while pready=1
- pslverr  out  1  error response, valid only while pready=1
- proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (prst=1 at an edge):
  - FSM to IDLE; all registers cleared to 0.
  - prdata=0, pslverr=0, proto_err=0, wait counter=0, latched address/control/data cleared.
  - pready=0 in the following cycle.
  - Reset during ACCESS aborts the transfer with no write performed.
- FSM has 2 states: IDLE and ACCESS.
- IDLE:
  - pready=0, pslverr=0.
  - On an edge with psel=1 and penable=0 (setup phase):
    - Latch paddr, pwrite, pwdata.
    - Compute err = (paddr[1:0]!=0) or (paddr >= DEPTH*4).
    - Load cnt <= WAIT_CYCLES.
    - If the access is a read with err=0: prdata <= reg[paddr>>2]; otherwise prdata <= 0.
    - Go to ACCESS.
  - psel=1 with penable=1 seen in IDLE (no setup phase): set proto_err, stay IDLE.
- ACCESS:
  - pready = (state==ACCESS) and (cnt==0). pready is decoded from registered state only, with no combinational path from inputs.
  - pslverr = pready and latched err.
  - Each edge with psel=1, penable=1 and cnt!=0: cnt decrements.
  - Edge with psel=1, penable=1 and cnt==0 (completion):
    - If latched pwrite=1 and err=0, reg[addr>>2] <= latched pwdata.
    - Return to IDLE. The same edge is not treated as a new setup phase.
  - Edge with psel=0 or penable=0 before completion: abort. No write, proto_err <= 1, return to IDLE.
- Latency:
  - Setup cycle, then WAIT_CYCLES+1 access cycles.
  - WAIT_CYCLES=0 gives the standard 2-cycle APB transfer.
- Back-to-back transfers: the cycle after completion may be the next setup phase; IDLE samples it at the next edge, so there are no dead cycles.
- Write then read of the same address back-to-back returns the new data, because the write commits at the completion edge, before the read's setup edge.
- Address and data changes by the master during ACCESS are ignored; the latched values are used.
- prdata holds its value after completion until the next setup edge.
- Errored writes never modify the register file. Errored reads return prdata=0 with pslverr=1.
- proto_err clears only on reset.
- Register index uses paddr[$clog2(DEPTH)+1:2].

Test Plan:
- Reset with WAIT_CYCLES=0:
  - Write 0xDEADBEEF to 0x08 -> pready=1 in the first access cycle, pslverr=0.
  - Read 0x08 -> prdata=0xDEADBEEF with pready=1, exactly 2 cycles per transfer.
- WAIT_CYCLES=3:
  - Read 0x04 after reset -> pready low for 3 access cycles and high on the 4th; prdata=0x00000000.
  - Write 0x12345678 to 0x04, then read back -> 0x12345678.
- Errors:
  - Write 0xA5A5A5A5 to 0x40 (DEPTH=16, out of range) -> pslverr=1 with pready.
  - Read 0x06 (misaligned) -> pslverr=1, prdata=0.
  - Every register still reads 0.
- Back-to-back writes to 0x00, 0x04, 0x3C (values 1, 2, 3) followed immediately by reads -> no idle gaps, read data 1, 2, 3, pslverr=0.
- Protocol violations:
  - Drop psel during ACCESS with WAIT_CYCLES=2 on a write of 0xFF to 0x0C -> proto_err=1, 0x0C still reads 0, next legal transfer completes normally.
  - psel=1 with penable=1 in IDLE -> proto_err=1.
- Assert prst during a wait-state write to 0x10 -> pready=0, proto_err=0 and all outputs 0 after reset; 0x10 reads 0.
